// File: rtl/vga_sync_generator.sv
// vga_sync_generator: 640x480@60 VGA horizontal/vertical timing, advanced by rising edges of PixelClock.
// Optional feature: define VGA_FRAME_COUNT_EN to add the 8-bit FrameCount output and its register.
module vga_sync_generator #(
  parameter int CountWidth  = 10,
  parameter int HVisible    = 640,
  parameter int HFrontPorch = 16,
  parameter int HSyncWidth  = 96,
  parameter int HBackPorch  = 48,
  parameter int VVisible    = 480,
  parameter int VFrontPorch = 10,
  parameter int VSyncWidth  = 2,
  parameter int VBackPorch  = 33
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  PixelClock,
  output logic                  HSync,
  output logic                  VSync,
  output logic                  Blank,
  output logic [CountWidth-1:0] PixelX,
  output logic [CountWidth-1:0] PixelY,
`ifdef VGA_FRAME_COUNT_EN
  output logic                  FrameStart,
  output logic [7:0]            FrameCount
`else
  output logic                  FrameStart
`endif
);

  localparam int HTotal = HVisible + HFrontPorch + HSyncWidth + HBackPorch;
  localparam int VTotal = VVisible + VFrontPorch + VSyncWidth + VBackPorch;

  localparam logic [CountWidth-1:0] HLast    = CountWidth'(HTotal - 1);
  localparam logic [CountWidth-1:0] VLast    = CountWidth'(VTotal - 1);
  localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

  // Thresholds are compared at 32 bits so a sync end equal to 2^CountWidth still works.
  localparam logic [31:0] HVisibleW   = 32'(HVisible);
  localparam logic [31:0] HSyncStartW = 32'(HVisible + HFrontPorch);
  localparam logic [31:0] HSyncEndW   = 32'(HVisible + HFrontPorch + HSyncWidth);
  localparam logic [31:0] VVisibleW   = 32'(VVisible);
  localparam logic [31:0] VSyncStartW = 32'(VVisible + VFrontPorch);
  localparam logic [31:0] VSyncEndW   = 32'(VVisible + VFrontPorch + VSyncWidth);

  logic                  pixelClockQ_r;
  logic                  tick_s;
  logic [CountWidth-1:0] hCount_r;
  logic [CountWidth-1:0] vCount_r;
  logic [CountWidth-1:0] hNext_s;
  logic [CountWidth-1:0] vNext_s;
  logic                  frameWrap_s;
  logic [31:0]           hWide_s;
  logic [31:0]           vWide_s;
  logic                  hSyncNext_s;
  logic                  vSyncNext_s;
  logic                  blankNext_s;
  logic                  hSync_r;
  logic                  vSync_r;
  logic                  blank_r;
  logic                  frameStart_r;

  assign tick_s = PixelClock & ~pixelClockQ_r;

  // Delayed copy of PixelClock for rising-edge detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pixelClockQ_r <= 1'b0;
    end else begin
      pixelClockQ_r <= PixelClock;
    end
  end

  // Next counter position: advance on a tick, wrap the line, and wrap the frame on the last line.
  always_comb begin
    hNext_s     = hCount_r;
    vNext_s     = vCount_r;
    frameWrap_s = 1'b0;
    if (tick_s) begin
      if (hCount_r == HLast) begin
        hNext_s = {CountWidth{1'b0}};
        if (vCount_r == VLast) begin
          vNext_s     = {CountWidth{1'b0}};
          frameWrap_s = 1'b1;
        end else begin
          vNext_s = vCount_r + CountOne;
        end
      end else begin
        hNext_s = hCount_r + CountOne;
      end
    end else begin
      hNext_s = hCount_r;
      vNext_s = vCount_r;
    end
  end

  // Decode from the next position so registered syncs line up with PixelX/PixelY.
  always_comb begin
    hWide_s     = 32'(hNext_s);
    vWide_s     = 32'(vNext_s);
    hSyncNext_s = ~((hWide_s >= HSyncStartW) && (hWide_s < HSyncEndW));
    vSyncNext_s = ~((vWide_s >= VSyncStartW) && (vWide_s < VSyncEndW));
    blankNext_s = (hWide_s >= HVisibleW) | (vWide_s >= VVisibleW);
  end

  // Counter and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hCount_r     <= {CountWidth{1'b0}};
      vCount_r     <= {CountWidth{1'b0}};
      hSync_r      <= 1'b1;
      vSync_r      <= 1'b1;
      blank_r      <= 1'b0;
      frameStart_r <= 1'b0;
    end else begin
      hCount_r     <= hNext_s;
      vCount_r     <= vNext_s;
      hSync_r      <= hSyncNext_s;
      vSync_r      <= vSyncNext_s;
      blank_r      <= blankNext_s;
      frameStart_r <= frameWrap_s;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frameCount_r;

  // Frame counter steps together with FrameStart and rolls over naturally at 8 bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frameCount_r <= 8'd0;
    end else if (frameWrap_s) begin
      frameCount_r <= frameCount_r + 8'd1;
    end else begin
      frameCount_r <= frameCount_r;
    end
  end

  assign FrameCount = frameCount_r;
`endif

  assign HSync      = hSync_r;
  assign VSync      = vSync_r;
  assign Blank      = blank_r;
  assign PixelX     = hCount_r;
  assign PixelY     = vCount_r;
  assign FrameStart = frameStart_r;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default geometry plus two shrunken geometries so frame wraps fit in a short run.
// Build with VGA_FRAME_COUNT_EN defined to also exercise FrameCount.
`timescale 1ns/1ps
module tb_vga_sync_generator;

  logic Clock      = 1'b0;
  logic Reset      = 1'b1;
  logic PixelClock = 1'b0;
  logic cmpOn      = 1'b0;

  always #5 Clock = ~Clock;

  logic       fullHs, fullVs, fullBl, fullFs;
  logic [9:0] fullX, fullY;
  logic       smallHs, smallVs, smallBl, smallFs;
  logic [4:0] smallX, smallY;
  logic       tinyHs, tinyVs, tinyBl, tinyFs;
  logic [1:0] tinyX, tinyY;
  int         fullFcI, smallFcI, tinyFcI;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fullFc, smallFc, tinyFc;
  assign fullFcI  = 32'(fullFc);
  assign smallFcI = 32'(smallFc);
  assign tinyFcI  = 32'(tinyFc);
`else
  assign fullFcI  = -1;
  assign smallFcI = -1;
  assign tinyFcI  = -1;
`endif

  vga_sync_generator dutFull (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(fullHs), .VSync(fullVs), .Blank(fullBl),
    .PixelX(fullX), .PixelY(fullY), .FrameStart(fullFs)
`ifdef VGA_FRAME_COUNT_EN
    , .FrameCount(fullFc)
`endif
  );

  vga_sync_generator #(
    .CountWidth(5), .HVisible(16), .HFrontPorch(4), .HSyncWidth(6), .HBackPorch(6),
    .VVisible(12), .VFrontPorch(2), .VSyncWidth(2), .VBackPorch(4)
  ) dutSmall (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(smallHs), .VSync(smallVs), .Blank(smallBl),
    .PixelX(smallX), .PixelY(smallY), .FrameStart(smallFs)
`ifdef VGA_FRAME_COUNT_EN
    , .FrameCount(smallFc)
`endif
  );

  vga_sync_generator #(
    .CountWidth(2), .HVisible(2), .HFrontPorch(1), .HSyncWidth(1), .HBackPorch(0),
    .VVisible(1), .VFrontPorch(1), .VSyncWidth(1), .VBackPorch(0)
  ) dutTiny (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(tinyHs), .VSync(tinyVs), .Blank(tinyBl),
    .PixelX(tinyX), .PixelY(tinyY), .FrameStart(tinyFs)
`ifdef VGA_FRAME_COUNT_EN
    , .FrameCount(tinyFc)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: ticks since reset and whether the last Clock edge consumed one.
  int   ticks      = 0;
  logic justTicked = 1'b0;
  logic pcPrev     = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ticks      <= 0;
      justTicked <= 1'b0;
      pcPrev     <= 1'b0;
    end else begin
      justTicked <= PixelClock & ~pcPrev;
      if (PixelClock && !pcPrev) ticks <= ticks + 1;
      pcPrev <= PixelClock;
    end
  end

  task automatic expectEq(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Expected outputs of one geometry, derived from the elapsed tick count alone.
  task automatic checkCfg(input string name, input int hv, input int hfp, input int hs, input int hbp,
                          input int vv, input int vfp, input int vs, input int vbp,
                          input int x, input int y, input int hsync, input int vsync,
                          input int blank, input int fs, input int fc);
    int ht, vt, ex, ey, eh, ev, eb, ef, efc;
    ht  = hv + hfp + hs + hbp;
    vt  = vv + vfp + vs + vbp;
    ex  = ticks % ht;
    ey  = (ticks / ht) % vt;
    eh  = (ex >= hv + hfp && ex < hv + hfp + hs) ? 0 : 1;
    ev  = (ey >= vv + vfp && ey < vv + vfp + vs) ? 0 : 1;
    eb  = (ex >= hv || ey >= vv) ? 1 : 0;
    ef  = (justTicked && (ticks % (ht * vt) == 0)) ? 1 : 0;
    efc = (ticks / (ht * vt)) % 256;
    checks++;
    if (x !== ex || y !== ey || hsync !== eh || vsync !== ev || blank !== eb || fs !== ef ||
        (fc >= 0 && fc !== efc)) begin
      errors++;
      $display("FAIL %s@tick%0d: got x=%0d y=%0d hs=%0d vs=%0d bl=%0d fs=%0d fc=%0d, want x=%0d y=%0d hs=%0d vs=%0d bl=%0d fs=%0d fc=%0d",
               name, ticks, x, y, hsync, vsync, blank, fs, fc, ex, ey, eh, ev, eb, ef, efc);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge Clock) begin
    if (cmpOn) begin
      checkCfg("full", 640, 16, 96, 48, 480, 10, 2, 33, 32'(fullX), 32'(fullY),
               32'(fullHs), 32'(fullVs), 32'(fullBl), 32'(fullFs), fullFcI);
      checkCfg("small", 16, 4, 6, 6, 12, 2, 2, 4, 32'(smallX), 32'(smallY),
               32'(smallHs), 32'(smallVs), 32'(smallBl), 32'(smallFs), smallFcI);
      checkCfg("tiny", 2, 1, 1, 0, 1, 1, 1, 0, 32'(tinyX), 32'(tinyY),
               32'(tinyHs), 32'(tinyVs), 32'(tinyBl), 32'(tinyFs), tinyFcI);
    end
  end

  // Spacing between consecutive FrameStart pulses of the small geometry (32 x 20 = 640 ticks).
  int lastFsTick = -1;
  int fsPulses   = 0;
  always @(negedge Clock) begin
    if (Reset) begin
      lastFsTick <= -1;
      fsPulses   <= 0;
    end else if (smallFs) begin
      if (lastFsTick >= 0) expectEq("smallFrameGap", ticks - lastFsTick, 640);
      lastFsTick <= ticks;
      fsPulses   <= fsPulses + 1;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  int fcSeen[$];
  always @(negedge Clock) begin
    if (!Reset && tinyFs) fcSeen.push_back(32'(tinyFc));
  end
`endif

  task automatic pixelCycles(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      PixelClock = 1'b1;
      repeat (hi) @(posedge Clock);
      #1;
      PixelClock = 1'b0;
      repeat (lo) @(posedge Clock);
      #1;
    end
  endtask

  task automatic runTicks(input int n);
    pixelCycles(1, 1, n);
  endtask

  initial begin
    @(posedge Clock);
    #1;
    cmpOn = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    expectEq("rstX", 32'(fullX), 0);
    expectEq("rstHSync", 32'(fullHs), 1);
    expectEq("rstVSync", 32'(fullVs), 1);
    expectEq("rstBlank", 32'(fullBl), 0);
    expectEq("rstFrameStart", 32'(fullFs), 0);
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    expectEq("noStartAtResetExit", 32'(smallFs), 0);

    // Slow pixel clock: 2 high, 2 low.
    pixelCycles(2, 2, 3);
    expectEq("slowX", 32'(fullX), 3);
    PixelClock = 1'b1;
    @(negedge Clock);
    expectEq("latencyBefore", 32'(fullX), 3);
    @(posedge Clock);
    #1;
    expectEq("latencyAfter", 32'(fullX), 4);
    repeat (20) @(posedge Clock);
    #1;
    expectEq("holdHigh", 32'(fullX), 4);
    PixelClock = 1'b0;
    @(posedge Clock);
    #1;

    // Horizontal decode of the default geometry.
    runTicks(636);
    expectEq("x640", 32'(fullX), 640);
    expectEq("blankAt640", 32'(fullBl), 1);
    expectEq("hsAt640", 32'(fullHs), 1);
    expectEq("smallWrapX", 32'(smallX), 0);
    expectEq("smallWrapY", 32'(smallY), 0);
    runTicks(15);
    expectEq("hsAt655", 32'(fullHs), 1);
    runTicks(1);
    expectEq("x656", 32'(fullX), 656);
    expectEq("hsAt656", 32'(fullHs), 0);
    runTicks(95);
    expectEq("hsAt751", 32'(fullHs), 0);
    runTicks(1);
    expectEq("hsAt752", 32'(fullHs), 1);
    runTicks(47);
    expectEq("x799", 32'(fullX), 799);
    expectEq("y0", 32'(fullY), 0);
    runTicks(1);
    expectEq("lineWrapX", 32'(fullX), 0);
    expectEq("lineWrapY", 32'(fullY), 1);
    expectEq("blankAt0", 32'(fullBl), 0);
    runTicks(1100);
    expectEq("x300", 32'(fullX), 300);
    expectEq("y2", 32'(fullY), 2);

    // Asynchronous reset mid-line.
    #2 Reset = 1'b1;
    #1;
    expectEq("midRstX", 32'(fullX), 0);
    expectEq("midRstY", 32'(fullY), 0);
    expectEq("midRstHSync", 32'(fullHs), 1);
    expectEq("midRstVSync", 32'(fullVs), 1);
    expectEq("midRstBlank", 32'(fullBl), 0);
    expectEq("midRstFrameStart", 32'(fullFs), 0);
    expectEq("midRstSmallX", 32'(smallX), 0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
`ifdef VGA_FRAME_COUNT_EN
    fcSeen.delete();
`endif
    @(posedge Clock);
    #1;

    // Vertical decode and frame wrap of the small geometry.
    runTicks(447);
    expectEq("smallX31", 32'(smallX), 31);
    expectEq("smallY13", 32'(smallY), 13);
    expectEq("smallVsAt13", 32'(smallVs), 1);
    runTicks(1);
    expectEq("smallY14", 32'(smallY), 14);
    expectEq("smallVsAt14", 32'(smallVs), 0);
    runTicks(64);
    expectEq("smallY16", 32'(smallY), 16);
    expectEq("smallVsAt16", 32'(smallVs), 1);
    runTicks(127);
    expectEq("smallLastX", 32'(smallX), 31);
    expectEq("smallLastY", 32'(smallY), 19);
    PixelClock = 1'b1;
    @(posedge Clock);
    #1;
    expectEq("frameWrapX", 32'(smallX), 0);
    expectEq("frameWrapY", 32'(smallY), 0);
    expectEq("frameWrapStart", 32'(smallFs), 1);
    expectEq("frameWrapBlank", 32'(smallBl), 0);
    expectEq("frameWrapHSync", 32'(smallHs), 1);
    expectEq("frameWrapVSync", 32'(smallVs), 1);
    PixelClock = 1'b0;
    @(posedge Clock);
    #1;
    expectEq("frameStartOneClock", 32'(smallFs), 0);

    // Line 10 to line 11 in the default geometry.
    runTicks(8159);
    expectEq("x799y10X", 32'(fullX), 799);
    expectEq("x799y10Y", 32'(fullY), 10);
    runTicks(1);
    expectEq("y11X", 32'(fullX), 0);
    expectEq("y11Y", 32'(fullY), 11);
    expectEq("smallFrames", fsPulses, 13);

`ifdef VGA_FRAME_COUNT_EN
    expectEq("fcSeenEnough", (fcSeen.size() >= 257) ? 1 : 0, 1);
    for (int i = 0; i < 257 && i < fcSeen.size(); i++) begin
      expectEq($sformatf("fcSeq[%0d]", i), fcSeen[i], (i + 1) % 256);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Generates 640×480@60 Hz VGA horizontal and vertical timing from the pixel-rate square wave produced by the upstream clock divider. It runs entirely in the system `Clock` domain and uses rising edges of `PixelClock` as a one-cycle advance enable. Its outputs are sync pulses, a blanking flag and the current pixel coordinates, which drive the downstream Pong renderer and the VGA pins.

## Interface
Parameters:
- `CountWidth`, 10: width of the horizontal and vertical counters and the coordinate outputs.
- `HVisible`, 640; `HFrontPorch`, 16; `HSyncWidth`, 96; `HBackPorch`, 48: horizontal segments, in pixels.
- `VVisible`, 480; `VFrontPorch`, 10; `VSyncWidth`, 2; `VBackPorch`, 33: vertical segments, in lines.
- Constraint: `HTotal` (sum of the horizontal segments, 800) and `VTotal` (sum of the vertical segments, 525) are each ≤ 2^`CountWidth`.

Ports:
- `Clock`, input, 1: system clock.
- `Reset`, input, 1: reset, asynchronous, active-high.
- `PixelClock`, input, 1: pixel-rate square wave, synchronous to `Clock`, low during reset.
- `HSync`, output, 1: horizontal sync, active-low.
- `VSync`, output, 1: vertical sync, active-low.
- `Blank`, output, 1: high outside the visible region.
- `PixelX`, output, `CountWidth`: current horizontal count, 0..`HTotal`-1.
- `PixelY`, output, `CountWidth`: current vertical count, 0..`VTotal`-1.
- `FrameStart`, output, 1: one-`Clock` pulse when the counters enter (0,0).
- `FrameCount`, output, 8: present only with `VGA_FRAME_COUNT_EN`.

## Operation
- Edge detect:
  - `PixelClockQ` is a register holding `PixelClock` delayed by one `Clock`.
  - `Tick = PixelClock & ~PixelClockQ`.
  - Exactly one `Tick` per `PixelClock` period.
  - `PixelClock` held constant (high or low) produces no ticks, and the counters freeze.
- Horizontal counter `HCount`: advances by 1 on each `Tick`. At `HTotal`-1 it wraps to 0.
- Vertical counter `VCount`: advances by 1 only on a `Tick` where `HCount` wraps. At `VTotal`-1, coinciding with the `HCount` wrap, it wraps to 0.
- Decode (unsigned compares on the counter values):
  - `HSync` = 0 iff `HVisible+HFrontPorch` ≤ `HCount` < `HVisible+HFrontPorch+HSyncWidth`. With defaults this is 656..751.
  - `VSync` = 0 iff `VVisible+VFrontPorch` ≤ `VCount` < `VVisible+VFrontPorch+VSyncWidth`. With defaults this is 490..491.
  - `Blank` = (`HCount` ≥ `HVisible`) | (`VCount` ≥ `VVisible`).
- `PixelX` = `HCount`; `PixelY` = `VCount`.
- `FrameStart` = 1 for exactly the one `Clock` in which the counters first show (0,0) after a wrap. It is not asserted at reset exit.
- All outputs are registered.
- Decode is computed from the next-state counter values, so `HSync`, `VSync`, `Blank` and `FrameStart` are always consistent with `PixelX`/`PixelY` in the same cycle.

## Timing
- Reset values:
  - `HCount` = 0, `VCount` = 0.
  - `HSync` = 1, `VSync` = 1.
  - `Blank` = 0, since (0,0) is visible.
  - `FrameStart` = 0, `FrameCount` = 0, `PixelClockQ` = 0.
- Latency:
  - `PixelClock` rises at `Clock` edge n.
  - `Tick` is high during cycle n.
  - Counters and all outputs update at edge n+1.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Counting resumes from (0,0) on the first `PixelClock` rising edge after `Reset` deasserts.
- Simultaneous events: on the final `Tick` of a frame (799,524 with defaults), in one edge:
  - `HCount` wraps to 0 and `VCount` wraps to 0.
  - `FrameStart` pulses.
  - `FrameCount` increments.
  - `HSync`, `VSync` and `Blank` all take their (0,0) values.
- No other wrap-around conditions exist: counters never exceed `Total`-1.

## Configuration
- `VGA_FRAME_COUNT_EN` defined:
  - The 8-bit `FrameCount` port and its register exist.
  - It increments in the same cycle `FrameStart` is asserted.
  - It wraps 255→0.
  - It resets to 0.
- `VGA_FRAME_COUNT_EN` undefined: no `FrameCount` port and no register. All other behaviour is identical.

## Test plan
- Reset check: assert `Reset` mid-line at count (300,200) -> the same cycle shows `PixelX`=0, `PixelY`=0, `HSync`=1, `VSync`=1, `Blank`=0, `FrameStart`=0.
- Tick rate: `PixelClock` with 4-`Clock` period (2 high, 2 low) -> `PixelX` advances by 1 every 4 `Clock`s, one `Clock` after each `PixelClock` rise. Holding `PixelClock`=1 for 20 cycles -> no advance.
- Horizontal decode:
  - `HSync` falls when `PixelX` becomes 656 and rises when `PixelX` becomes 752.
  - `Blank` rises at `PixelX`=640 and falls at `PixelX`=0.
  - One line spans 800 ticks.
- Line and frame wrap:
  - (799,10) -> (0,11).
  - `VSync` = 0 exactly for `PixelY` 490 and 491.
  - (799,524) -> (0,0) with `FrameStart` = 1 for one `Clock`.
  - Two consecutive `FrameStart` pulses are 420000 ticks apart.
- Frame counter, with `VGA_FRAME_COUNT_EN`: run 257 frames -> `FrameCount` sequence 1..255, 0, 1.
- Frame counter, without the macro: the build elaborates with no `FrameCount` port.
